// File: rtl/kbd_ctrl_pkg.sv
// Shared key codes, case-fold mask and transport state encodings for the keyboard playback controller.
// Constants only: no latency and no flow control.
package kbd_ctrl_pkg;

    localparam logic [7:0] KEY_E     = 8'h45;
    localparam logic [7:0] KEY_D     = 8'h44;
    localparam logic [7:0] KEY_B     = 8'h42;
    localparam logic [7:0] KEY_F     = 8'h46;
    localparam logic [7:0] KEY_R     = 8'h52;
    localparam logic [7:0] KEY_U     = 8'h55;
    localparam logic [7:0] KEY_S     = 8'h53;
    localparam logic [7:0] KEY_N     = 8'h4E;
    localparam logic [7:0] CASE_MASK = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAY    = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_RESTART = 2'b11
    } state_t;

endpackage

// File: rtl/sample_rate_divider.sv
// Down-counter emitting a one-cycle tick every load_val enabled cycles; clr parks the counter at zero.
// Tick is registered (one cycle after the zero count); no backpressure, the consumer must take every tick.
module sample_rate_divider #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == '0) begin
                // Reload samples the divider now, so speed changes land on the next period.
                cnt_d  = load_val - W'(1);
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/kbd_playback_ctrl.sv
// Keyboard transport control for flash playback: play/pause, direction, restart handshake, sample-rate divider.
// Commands act the cycle after the kbd_data_ready rising edge; no backpressure, one command per key press.
module kbd_playback_ctrl
    import kbd_ctrl_pkg::*;
#(
    parameter int unsigned KEY_W    = 8,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned DIV_NOM  = 2272,
    parameter int unsigned DIV_STEP = 128,
    parameter int unsigned DIV_MIN  = 568,
    parameter int unsigned DIV_MAX  = 9088
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] keyboardIp,
    input  logic             kbd_data_ready,
    input  logic             restart_done,
    output logic             play_en,
    output logic             is_fwrd,
    output logic             restart_req,
    output logic             sample_tick,
    output logic [DIV_W-1:0] div_value,
    output logic [1:0]       state
);

    localparam logic [DIV_W:0]   STEP_X = (DIV_W+1)'(DIV_STEP);
    localparam logic [DIV_W:0]   MIN_X  = (DIV_W+1)'(DIV_MIN);
    localparam logic [DIV_W:0]   MAX_X  = (DIV_W+1)'(DIV_MAX);
    localparam logic [DIV_W-1:0] NOM_V  = DIV_W'(DIV_NOM);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             rdy_prev_q, rdy_prev_d;
    logic             cmd_vld;
    logic [KEY_W-1:0] key_fold;
    logic [DIV_W:0]   div_dec, div_inc;
    logic             div_en, div_clr;

    assign cmd_vld  = kbd_data_ready & ~rdy_prev_q;
    assign key_fold = keyboardIp & ~KEY_W'(CASE_MASK);
    assign div_dec  = {1'b0, div_q} - STEP_X;
    assign div_inc  = {1'b0, div_q} + STEP_X;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        div_d      = div_q;
        rdy_prev_d = kbd_data_ready;
        // A reload acknowledgement outranks any key arriving in the same cycle.
        if (state_q == ST_RESTART && restart_done) begin
            state_d = ST_PLAY;
        end else if (cmd_vld) begin
            case (key_fold)
                KEY_W'(KEY_E): if (state_q == ST_IDLE || state_q == ST_PAUSE) state_d = ST_PLAY;
                KEY_W'(KEY_D): if (state_q == ST_PLAY) state_d = ST_PAUSE;
                KEY_W'(KEY_R): if (state_q == ST_PLAY || state_q == ST_PAUSE) state_d = ST_RESTART;
                KEY_W'(KEY_F): dir_d = 1'b1;
                KEY_W'(KEY_B): begin
                    dir_d = 1'b0;
                    if (state_q == ST_IDLE) state_d = ST_PLAY;
                end
                KEY_W'(KEY_U): div_d = (div_dec[DIV_W] || div_dec < MIN_X) ? MIN_X[DIV_W-1:0] : div_dec[DIV_W-1:0];
                KEY_W'(KEY_S): div_d = (div_inc > MAX_X) ? MAX_X[DIV_W-1:0] : div_inc[DIV_W-1:0];
                KEY_W'(KEY_N): div_d = NOM_V;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b1;
            div_q      <= NOM_V;
            rdy_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            div_q      <= div_d;
            rdy_prev_q <= rdy_prev_d;
        end
    end

    // Count only while staying in PLAY so a tick can never land after play_en drops.
    assign div_en  = (state_q == ST_PLAY) && (state_d == ST_PLAY);
    assign div_clr = (state_q == ST_RESTART);

    sample_rate_divider #(
        .W (DIV_W)
    ) u_divider (
        .clk      (clk),
        .rst      (reset),
        .en       (div_en),
        .clr      (div_clr),
        .load_val (div_q),
        .tick     (sample_tick)
    );

    assign play_en     = (state_q == ST_PLAY);
    assign restart_req = (state_q == ST_RESTART);
    assign is_fwrd     = dir_q;
    assign div_value   = div_q;
    assign state       = state_q;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Bench for kbd_playback_ctrl: directed transport scenarios plus a random key stream against a table-driven model.
module tb_kbd_playback_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  keyboardIp;
    logic        kbd_data_ready;
    logic        restart_done;
    logic        play_en, is_fwrd, restart_req, sample_tick;
    logic [15:0] div_value;
    logic [1:0]  state;

    int n_checks   = 0;
    int n_fail     = 0;
    int tick_total = 0;
    int tick_viol  = 0;

    kbd_playback_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .keyboardIp     (keyboardIp),
        .kbd_data_ready (kbd_data_ready),
        .restart_done   (restart_done),
        .play_en        (play_en),
        .is_fwrd        (is_fwrd),
        .restart_req    (restart_req),
        .sample_tick    (sample_tick),
        .div_value      (div_value),
        .state          (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample_tick) tick_total++;
        if (sample_tick && !play_en) tick_viol++;
    end

    task automatic press(input logic [7:0] k, input int hold);
        keyboardIp     = k;
        kbd_data_ready = 1'b1;
        repeat (hold) @(negedge clk);
        kbd_data_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tick(input int budget, output bit ok, output longint t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sample_tick) begin
                ok = 1'b1;
                t  = longint'($time);
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; keyboardIp = 8'h00; kbd_data_ready = 1'b0; restart_done = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (play_en !== 1'b0) begin n_fail++; $display("FAIL reset_play_en: got %b want 0", play_en); end
        n_checks++; if (is_fwrd !== 1'b1) begin n_fail++; $display("FAIL reset_is_fwrd: got %b want 1", is_fwrd); end
        n_checks++; if (restart_req !== 1'b0) begin n_fail++; $display("FAIL reset_restart_req: got %b want 0", restart_req); end
        n_checks++; if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", sample_tick); end
        n_checks++; if (div_value !== 16'd2272) begin n_fail++; $display("FAIL reset_div: got %0d want 2272", div_value); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL post_reset_state: got %0d want 0", state); end
    endtask

    task automatic test_play_key;
        keyboardIp = 8'h65;
        kbd_data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL play_hold_state[%0d]: got %0d want 1", i, state); end
        end
        kbd_data_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (play_en !== 1'b1) begin n_fail++; $display("FAIL play_en: got %b want 1", play_en); end
        n_checks++; if (is_fwrd !== 1'b1) begin n_fail++; $display("FAIL play_is_fwrd: got %b want 1", is_fwrd); end
    endtask

    task automatic test_tick_period;
        bit ok0, ok1, ok2;
        longint t0, t1, t2;
        int snap;
        wait_tick(5000, ok0, t0);
        wait_tick(3000, ok1, t1);
        wait_tick(3000, ok2, t2);
        n_checks++; if (!(ok0 && ok1 && ok2)) begin n_fail++; $display("FAIL nom_tick_timeout: got %b%b%b want 111", ok0, ok1, ok2); end
        n_checks++; if ((t1 - t0) / 10 != 2272) begin n_fail++; $display("FAIL nom_period1: got %0d want 2272", (t1 - t0) / 10); end
        n_checks++; if ((t2 - t1) / 10 != 2272) begin n_fail++; $display("FAIL nom_period2: got %0d want 2272", (t2 - t1) / 10); end
        press(8'h44, 1);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_state: got %0d want 2", state); end
        n_checks++; if (play_en !== 1'b0) begin n_fail++; $display("FAIL pause_play_en: got %b want 0", play_en); end
        snap = tick_total;
        repeat (5000) @(negedge clk);
        n_checks++; if (tick_total != snap) begin n_fail++; $display("FAIL pause_ticks: got %0d want %0d", tick_total, snap); end
    endtask

    task automatic test_restart;
        press(8'h45, 1);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d want 1", state); end
        press(8'h52, 1);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL restart_state: got %0d want 3", state); end
        n_checks++; if (restart_req !== 1'b1) begin n_fail++; $display("FAIL restart_req: got %b want 1", restart_req); end
        n_checks++; if (play_en !== 1'b0) begin n_fail++; $display("FAIL restart_play_en: got %b want 0", play_en); end
        repeat (10) @(negedge clk);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL restart_hold: got %0d want 3", state); end
        restart_done = 1'b1;
        @(negedge clk);
        restart_done = 1'b0;
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL restart_exit: got %0d want 1", state); end
        n_checks++; if (restart_req !== 1'b0) begin n_fail++; $display("FAIL restart_req_drop: got %b want 0", restart_req); end
        n_checks++; if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL restart_tick_early: got %b want 0", sample_tick); end
        @(negedge clk);
        n_checks++; if (sample_tick !== 1'b1) begin n_fail++; $display("FAIL restart_first_tick: got %b want 1", sample_tick); end
    endtask

    task automatic test_speed;
        bit ok0, ok1;
        longint t0, t1;
        press(8'h75, 1);
        n_checks++; if (div_value !== 16'd2144) begin n_fail++; $display("FAIL faster_once: got %0d want 2144", div_value); end
        repeat (19) press(8'h55, 1);
        n_checks++; if (div_value !== 16'd568) begin n_fail++; $display("FAIL faster_sat: got %0d want 568", div_value); end
        wait_tick(3000, ok0, t0);
        wait_tick(1000, ok1, t1);
        n_checks++; if (!(ok0 && ok1) || (t1 - t0) / 10 != 568) begin n_fail++; $display("FAIL fast_period: got %0d ok=%b%b want 568", (t1 - t0) / 10, ok0, ok1); end
        repeat (80) press(8'h73, 1);
        n_checks++; if (div_value !== 16'd9088) begin n_fail++; $display("FAIL slower_sat: got %0d want 9088", div_value); end
        wait_tick(20000, ok0, t0);
        wait_tick(20000, ok1, t1);
        n_checks++; if (!(ok0 && ok1) || (t1 - t0) / 10 != 9088) begin n_fail++; $display("FAIL slow_period: got %0d ok=%b%b want 9088", (t1 - t0) / 10, ok0, ok1); end
        press(8'h6E, 1);
        n_checks++; if (div_value !== 16'd2272) begin n_fail++; $display("FAIL nominal_key: got %0d want 2272", div_value); end
    endtask

    task automatic test_restart_collision;
        press(8'h72, 1);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL coll_enter: got %0d want 3", state); end
        keyboardIp = 8'h44; kbd_data_ready = 1'b1; restart_done = 1'b1;
        @(negedge clk);
        restart_done = 1'b0;
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL coll_exit: got %0d want 1", state); end
        repeat (3) @(negedge clk);
        kbd_data_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL coll_discard: got %0d want 1", state); end
        press(8'h64, 1);
        press(8'h62, 2);
        n_checks++; if (is_fwrd !== 1'b0) begin n_fail++; $display("FAIL pause_back_dir: got %b want 0", is_fwrd); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_back_state: got %0d want 2", state); end
    endtask

    task automatic test_reset_mid_restart;
        repeat (14) press(8'h55, 1);
        press(8'h45, 1);
        press(8'h52, 1);
        n_checks++; if (state !== 2'd3 || div_value !== 16'd568) begin n_fail++; $display("FAIL mid_setup: got state %0d div %0d want 3/568", state, div_value); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (restart_req !== 1'b0) begin n_fail++; $display("FAIL mid_restart_req: got %b want 0", restart_req); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL mid_state: got %0d want 0", state); end
        n_checks++; if (div_value !== 16'd2272) begin n_fail++; $display("FAIL mid_div: got %0d want 2272", div_value); end
        n_checks++; if (is_fwrd !== 1'b1) begin n_fail++; $display("FAIL mid_dir: got %b want 1", is_fwrd); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0] keys [20] = '{8'h45, 8'h65, 8'h44, 8'h64, 8'h46, 8'h66, 8'h42, 8'h62, 8'h52, 8'h72,
                                  8'h55, 8'h75, 8'h53, 8'h73, 8'h4E, 8'h6E, 8'h78, 8'h41, 8'h31, 8'h20};
        int   m_state = 0;
        bit   m_dir   = 1'b1;
        int   m_div   = 2272;
        bit   m_prev  = 1'b0;
        bit   rdy, done, edge_seen;
        logic [7:0] f;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state@%0d: got %0d want %0d", cyc, state, m_state); end
            n_checks++; if (play_en !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_play_en@%0d: got %b want %b", cyc, play_en, m_state == 1); end
            n_checks++; if (restart_req !== (m_state == 3)) begin n_fail++; $display("FAIL rnd_restart_req@%0d: got %b want %b", cyc, restart_req, m_state == 3); end
            n_checks++; if (is_fwrd !== m_dir) begin n_fail++; $display("FAIL rnd_dir@%0d: got %b want %b", cyc, is_fwrd, m_dir); end
            n_checks++; if (div_value !== 16'(m_div)) begin n_fail++; $display("FAIL rnd_div@%0d: got %0d want %0d", cyc, div_value, m_div); end

            if ($urandom_range(0, 2) == 0) keyboardIp = keys[$urandom_range(0, 19)];
            rdy  = ($urandom_range(0, 2) == 0) ? !kbd_data_ready : kbd_data_ready;
            done = ($urandom_range(0, 7) == 0);
            kbd_data_ready = rdy;
            restart_done   = done;

            edge_seen = rdy && !m_prev;
            m_prev    = rdy;
            f         = keyboardIp & 8'hDF;
            if (m_state == 3 && done) begin
                m_state = 1;
            end else if (edge_seen) begin
                if (f == 8'h45 && (m_state == 0 || m_state == 2)) m_state = 1;
                else if (f == 8'h44 && m_state == 1) m_state = 2;
                else if (f == 8'h52 && (m_state == 1 || m_state == 2)) m_state = 3;
                else if (f == 8'h46) m_dir = 1'b1;
                else if (f == 8'h42) begin m_dir = 1'b0; if (m_state == 0) m_state = 1; end
                else if (f == 8'h55) m_div = (m_div - 128 < 568) ? 568 : m_div - 128;
                else if (f == 8'h53) m_div = (m_div + 128 > 9088) ? 9088 : m_div + 128;
                else if (f == 8'h4E) m_div = 2272;
            end
            @(negedge clk);
        end
        kbd_data_ready = 1'b0;
        restart_done   = 1'b0;
        @(negedge clk);
        n_checks++; if (tick_viol != 0) begin n_fail++; $display("FAIL tick_without_play: got %0d want 0", tick_viol); end
    endtask

    initial begin
        test_reset;
        test_play_key;
        test_tick_period;
        test_restart;
        test_speed;
        test_restart_collision;
        test_reset_mid_restart;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
